uart_tx_fifo: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the core's data-memory store path, alongside `ram`. Word stores from the core to the TX data address push a byte into an internal FIFO; an 8N1 serializer with a programmable baud divider drains it onto a serial line that feeds `uart_receiver`. A status word is readable at a second address so firmware can poll before storing.

---
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status word
module uart_tx_fifo #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_0104
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_write_en,
    output logic [31:0] o_rdata,
    output logic        o_tx,
    output logic        o_busy
);
    localparam int W  = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [W-1:0] wr_ptr_q, rd_ptr_q;
    logic [W:0]  count_q, count_d;
    logic        ovf_q;
    state_t      state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  sr_q;
    logic        tx_q, busy_q;

    logic wr_tx, wr_stat, empty, full, baud_last, push, pop;
    logic [31:0] stat;
    logic unused_wdata;

    assign wr_tx     = i_write_en && (i_addr == TX_ADDR);
    assign wr_stat   = i_write_en && (i_addr == STAT_ADDR);
    assign empty     = (count_q == '0);
    assign full      = (count_q == (W+1)'(FIFO_DEPTH));
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign push      = wr_tx && !full;
    // The serializer takes the next byte when idle, or on the last stop clock so frames abut.
    assign pop       = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
    assign unused_wdata = ^i_wdata[31:8];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_wdata[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_tx && full)                ovf_q <= 1'b1;
            else if (wr_stat && i_wdata[3])   ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            sr_q      <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            // Line and busy follow the state one clock later, so every bit keeps its full width.
            tx_q   <= (state_q == START) ? 1'b0 : (state_q == DATA) ? sr_q[0] : 1'b1;
            busy_q <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sr_q      <= mem_q[rd_ptr_q];
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        sr_q   <= sr_q >> 1;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                        else                   bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            sr_q      <= mem_q[rd_ptr_q];
                            bit_idx_q <= '0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stat          = '0;
        stat[0]       = empty;
        stat[1]       = full;
        stat[2]       = busy_q;
        stat[3]       = ovf_q;
        stat[4 +: W+1] = count_q;
    end

    assign o_rdata = (i_addr == STAT_ADDR) ? stat : 32'h0;
    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo against a timeline model
module tb_uart_tx_fifo;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TXA   = 32'h0000_0100;
    localparam logic [31:0] STA   = 32'h0000_0104;

    logic        clk, rst_n, write_en, o_tx, o_busy;
    logic [31:0] addr, wdata, o_rdata;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA), .STAT_ADDR(STA)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata),
        .i_write_en(write_en), .o_rdata(o_rdata), .o_tx(o_tx), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a frame occupies 10*CPB edges from its pop; the next pop may happen
    // on the edge that ends it. Occupancy, overflow and busy follow from that timeline.
    int          occ;
    longint      edge_num = 0, tx_free;
    bit          ovf_m, fsm_busy_m, busy_m;
    logic [7:0]  exp_q[$];
    longint      exp_start[$];
    int          frames = 0;
    longint      last_start = 0, prev_start = 0;

    task automatic model_reset();
        occ = 0; tx_free = 0; ovf_m = 0; fsm_busy_m = 0; busy_m = 0;
        exp_q.delete(); exp_start.delete();
    endtask

    task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit do_pop;
        edge_num++;
        if (!rst_n) begin model_reset(); return; end
        do_pop = (occ > 0) && (edge_num >= tx_free);
        busy_m = fsm_busy_m;
        if (we && a == TXA) begin
            if (occ == DEPTH) ovf_m = 1;
            else begin exp_q.push_back(d[7:0]); occ++; end
        end else if (we && a == STA && d[3]) ovf_m = 0;
        if (do_pop) begin
            occ--;
            tx_free = edge_num + 10 * CPB;
            exp_start.push_back(edge_num + 1);
        end
        fsm_busy_m = (edge_num < tx_free);
    endtask

    function automatic logic [31:0] exp_stat();
        logic [31:0] s;
        s = '0;
        s[0] = (occ == 0); s[1] = (occ == DEPTH); s[2] = busy_m; s[3] = ovf_m;
        s[7:4] = 4'(occ);
        return s;
    endfunction

    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
        write_en = we; addr = a; wdata = d;
        @(posedge clk);
        model_edge(we, a, d);
        #1 write_en = 0; addr = STA; wdata = 0;
        #1;
        check(o_rdata == exp_stat(), "status", o_rdata, exp_stat());
        check(o_busy == busy_m, "busy", {31'd0, o_busy}, {31'd0, busy_m});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, STA, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() > 0 || busy_m) && guard < 3000) begin idle(1); guard++; end
        idle(3);
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    // Monitor: decodes the line, requiring every bit to hold exactly CPB samples.
    logic [9:0] f_bits;
    bit         f_ok, f_abort;
    longint     f_start;
    logic [7:0] eb;
    longint     es;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_tx === 1'b0) begin
                f_start = edge_num; f_ok = 1; f_abort = 0; f_bits = '0;
                for (int s = 1; s < 10 * CPB; s++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin f_abort = 1; break; end
                    if (s % CPB == 0) f_bits[s / CPB] = o_tx;
                    else if (o_tx !== f_bits[s / CPB]) f_ok = 0;
                end
                if (!f_abort) begin
                    frames++;
                    prev_start = last_start; last_start = f_start;
                    check(f_ok && f_bits[9] && !f_bits[0], "frame_shape", {21'd0, f_ok, f_bits}, 32'h0000_0600);
                    if (exp_q.size() == 0) check(0, "unexpected_frame", {24'd0, f_bits[8:1]}, 0);
                    else begin
                        eb = exp_q.pop_front();
                        es = exp_start.pop_front();
                        check(f_bits[8:1] == eb, "frame_data", {24'd0, f_bits[8:1]}, {24'd0, eb});
                        check(f_start == es, "frame_start_edge", 32'(f_start), 32'(es));
                    end
                end
            end
        end
    end

    longint e_push;
    int     f0, sent, guard;
    int     r;
    initial begin
        rst_n = 0; write_en = 0; addr = STA; wdata = 0;
        model_reset();
        idle(3);
        rst_n = 1;
        #1;
        check(o_rdata == 32'h1, "reset_status", o_rdata, 32'h1);
        check(o_tx == 1'b1, "reset_tx", {31'd0, o_tx}, 32'h1);
        idle(2);

        // single byte: start bit two edges after the store, 40 clocks of frame
        step(1, TXA, 32'h1234_56A5);
        e_push = edge_num;
        drain();
        check(last_start == e_push + 2, "latency", 32'(last_start), 32'(e_push + 2));

        // back-to-back frames with no idle gap
        step(1, TXA, 32'h55);
        step(1, TXA, 32'h0F);
        drain();
        check(last_start - prev_start == 10 * CPB, "b2b_gap", 32'(last_start - prev_start), 10 * CPB);

        // fill: one byte goes to the serializer, eight fill the FIFO, the tenth is dropped
        f0 = frames;
        for (int i = 0; i < 10; i++) step(1, TXA, 32'h30 + i);
        addr = STA; #1;
        check(o_rdata[3] == 1'b1, "ovf_set", o_rdata, 32'h8);
        check(o_rdata[1] == 1'b1, "full_set", o_rdata, 32'h2);
        step(1, STA, 32'h8);
        check(o_rdata[3] == 1'b0, "ovf_clear", o_rdata, 32'h0);
        drain();
        check(frames - f0 == 9, "fill_frames", frames - f0, 9);

        // reset in the middle of a frame
        step(1, TXA, 32'hA5);
        step(1, TXA, 32'h3C);
        idle(10);
        rst_n = 0;
        #1;
        check(o_tx == 1'b1 && o_busy == 1'b0, "reset_abort", {30'd0, o_tx, o_busy}, 32'h2);
        model_reset();
        idle(2);
        rst_n = 1;
        idle(60);

        // wrap-around with polled stores
        sent = 0; guard = 0;
        while (sent < 20 && guard < 5000) begin
            addr = STA; #1;
            if (!o_rdata[1]) begin step(1, TXA, 32'(sent)); sent++; end
            else idle(1);
            guard++;
        end
        check(sent == 20, "poll_sent", sent, 20);
        drain();
        addr = STA; #1;
        check(o_rdata[3] == 1'b0, "poll_no_ovf", o_rdata, 32'h0);

        // address decode
        step(1, TXA + 8, 32'h77);
        idle(5);
        addr = TXA; #1;      check(o_rdata == 0, "rdata_tx_addr", o_rdata, 0);
        addr = TXA + 8; #1;  check(o_rdata == 0, "rdata_other", o_rdata, 0);
        addr = 32'h0; #1;    check(o_rdata == 0, "rdata_zero", o_rdata, 0);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      step(1, TXA, $urandom);
            else if (r == 6) step(1, STA, $urandom);
            else if (r == 7) step(1, 32'h0000_0108 + 32'($urandom_range(0, 3)) * 4, $urandom);
            else             idle($urandom_range(1, 30));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
